// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: scan-out owns pix_en&active slots, the game port
// gets the rest (queued writes first, then one read at a time behind them).
module vram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              active,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wreq_t;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_WR, SLOT_RD} slot_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_RD} tag_e;

  // write queue
  wreq_t             wq_mem [WQ_DEPTH];
  wreq_t             head;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic              wq_empty, push, pop;

  slot_e             slot;
  tag_e              slot_tag;
  tag_e              tag_pipe [2];

  assign head     = wq_mem[rptr];
  assign wq_empty = (count == '0);
  assign wr_ready = (count < CNT_W'(WQ_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = (slot == SLOT_WR);

  // Slot owner; reads wait on the registered count so a same-cycle push still
  // lands ahead of any later read.
  always_comb begin
    slot = SLOT_IDLE;
    if (!rst) begin
      if (pix_en && active)  slot = SLOT_DISP;
      else if (!wq_empty)    slot = SLOT_WR;
      else if (rd_valid)     slot = SLOT_RD;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_ready  = 1'b0;
    slot_tag  = TAG_NONE;
    unique case (slot)
      SLOT_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
        slot_tag = TAG_DISP;
      end
      SLOT_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
      end
      SLOT_RD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
        rd_ready = 1'b1;
        slot_tag = TAG_RD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) wq_mem[wptr] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Owner tag follows each slot for two cycles; RAM data arrives one cycle behind the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe[0] <= TAG_NONE;
      tag_pipe[1] <= TAG_NONE;
      disp_data   <= '0;
      rd_data     <= '0;
    end else begin
      tag_pipe[0] <= slot_tag;
      tag_pipe[1] <= tag_pipe[0];
      if (tag_pipe[0] == TAG_DISP) disp_data <= mem_rdata;
      if (tag_pipe[0] == TAG_RD)   rd_data   <= mem_rdata;
    end
  end

  assign disp_valid    = (tag_pipe[1] == TAG_DISP);
  assign rd_data_valid = (tag_pipe[1] == TAG_RD);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: RAM model, slot-rule checker and return-data queues.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_en = 1'b0, active = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0, rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #10 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .active(active),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // RAM device: preloaded with addr[7:0], read data one clk after the slot
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ld = 1'b1;
  always @(posedge clk) begin
    if (ld) begin
      for (int a = 0; a < (1<<AW); a++) ram[a] <= DW'(a);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // pixel strobe: toggles each clk unless held; display fetches walk 0x0100..0x01FF
  bit            pix_hold = 0;
  int            disp_idx = 0;
  initial forever begin
    @(posedge clk); #1;
    pix_en = pix_hold ? 1'b1 : ~pix_en;
    if (pix_en) begin
      disp_addr = 15'h0100 + AW'(disp_idx);
      disp_idx  = (disp_idx + 1) % 256;
    end
  end

  typedef struct {int cyc; logic [DW-1:0] data;} ret_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  ret_t          dq[$], rq[$];
  wr_t           wq[$];
  logic [DW-1:0] golden [0:(1<<AW)-1];
  bit            rd_acc = 0;
  int            we_cnt = 0, nr_cnt = 0, disp_cnt = 0;
  logic [DW-1:0] last_rd = '0;

  // monitor: slot rules from the model's pending-write list, returns from the queues
  initial begin
    bit   strobe, exp_we, exp_rd;
    wr_t  w;
    ret_t r;
    for (int a = 0; a < (1<<AW); a++) golden[a] = DW'(a);
    forever begin
      @(negedge clk);
      if (rst) begin
        dq.delete(); rq.delete(); wq.delete();
        rd_acc = 0;
      end else begin
        strobe = pix_en && active;
        exp_we = !strobe && (wq.size() > 0);
        exp_rd = !strobe && (wq.size() == 0) && rd_valid;
        chk("mem_en",   mem_en,   strobe || exp_we || exp_rd);
        chk("mem_we",   mem_we,   exp_we);
        chk("rd_ready", rd_ready, exp_rd);
        chk("wr_ready", wr_ready, wq.size() < D);
        if (strobe) begin
          chk("disp_slot_addr", mem_addr, disp_addr);
          r.cyc = cyc + 2; r.data = golden[disp_addr];
          dq.push_back(r);
        end
        if (exp_we && mem_we) begin
          w = wq.pop_front();
          chk("wr_order_addr", mem_addr, w.addr);
          chk("wr_order_data", mem_wdata, w.data);
          golden[w.addr] = w.data;
          we_cnt++;
        end
        if (exp_rd && rd_ready) begin
          chk("rd_slot_addr", mem_addr, rd_addr);
          r.cyc = cyc + 2; r.data = golden[rd_addr];
          rq.push_back(r);
        end
        rd_acc = rd_ready;
        if (!wr_ready) nr_cnt++;
        if (wr_valid && wr_ready) begin
          w.addr = wr_addr; w.data = wr_data;
          wq.push_back(w);
        end
        if (disp_valid) begin
          disp_cnt++;
          if (dq.size() == 0) chk("disp_valid_unexpected", 1, 0);
          else begin
            r = dq.pop_front();
            chk("disp_latency", cyc, r.cyc);
            chk("disp_data", disp_data, r.data);
          end
        end
        if (rd_data_valid) begin
          last_rd = rd_data;
          if (rq.size() == 0) chk("rd_valid_unexpected", 1, 0);
          else begin
            r = rq.pop_front();
            chk("rd_latency", cyc, r.cyc);
            chk("rd_data", rd_data, r.data);
          end
        end
        if (dq.size() > 0 && dq[0].cyc < cyc) begin chk("disp_missing", 0, 1); void'(dq.pop_front()); end
        if (rq.size() > 0 && rq[0].cyc < cyc) begin chk("rd_missing", 0, 1); void'(rq.pop_front()); end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int n, output logic pix_at);
    rd_valid = 1'b1; rd_addr = a; n = 0; pix_at = 1'b1;
    while (!rd_ready && n < 100) begin step(); n++; end
    chk("rd_grant_timeout", rd_ready, 1);
    pix_at = pix_en;
    step();
    rd_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, base;
    logic pa;
    @(posedge clk); #2 ld = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // reset with writes parked behind a busy RAM
    active = 1'b1; pix_hold = 1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 15'h0400 + AW'(i); wr_data = DW'(8'hC0 + i);
      step();
    end
    wr_valid = 1'b0; rst = 1'b1;
    repeat (3) step();
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    pix_hold = 0; active = 1'b0; rst = 1'b0;
    base = disp_cnt;
    repeat (10) step();
    chk("post_rst_no_disp", disp_cnt - base, 0);

    // scan-out priority with writes pressing on every cycle
    if (pix_en) step();
    disp_idx = 0; active = 1'b1;
    base = disp_cnt;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 15'h2000 + AW'($urandom_range(0, 15'h5FFF)); wr_data = DW'($urandom);
      step();
    end
    wr_valid = 1'b0; active = 1'b0;
    repeat (8) step();
    chk("scanout_pulses", disp_cnt - base, 8);

    // queue full while RAM busy, then in-order drain
    active = 1'b1; pix_hold = 1; step();
    base = we_cnt;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 15'h0300 + AW'(i); wr_data = DW'(8'hA0 + i);
      step();
    end
    wr_valid = 1'b0;
    chk("wq_full_ready", wr_ready, 0);
    step();
    pix_hold = 0; active = 1'b0;
    repeat (8) step();
    chk("wq_drain_count", we_cnt - base, 4);

    // read-after-write
    wr_valid = 1'b1; wr_addr = 15'h0040; wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    do_read(15'h0040, n, pa);
    chk("raw_withheld", n, 1);
    repeat (4) step();
    chk("raw_data", last_rd, 8'h5A);

    // blanking bandwidth
    base = we_cnt; n = nr_cnt;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 15'h2000 + AW'($urandom_range(0, 15'h5FFF)); wr_data = DW'($urandom);
      step();
    end
    wr_valid = 1'b0;
    repeat (4) step();
    chk("blank_writes", we_cnt - base, 8);
    chk("blank_ready_low", nr_cnt - n, 0);

    // read in active area
    active = 1'b1;
    do_read(15'h1234, n, pa);
    chk("mixed_grant_pix", pa, 0);
    repeat (4) step();
    chk("mixed_data", last_rd, 8'h34);

    // randomized traffic
    fork
      for (int i = 0; i < 400; i++) begin
        wr_valid = ($urandom % 3) != 0;
        wr_addr  = 15'h2000 + AW'($urandom_range(0, 15'h5FFF));
        wr_data  = DW'($urandom);
        step();
      end
      for (int i = 0; i < 20; i++) begin
        active = $urandom % 2;
        repeat (20) step();
      end
      for (int i = 0; i < 400; i++) begin
        step();
        if (rd_valid && rd_acc) rd_valid = 1'b0;
        else if (!rd_valid && ($urandom % 3) == 0) begin
          rd_valid = 1'b1; rd_addr = AW'($urandom);
        end
      end
    join
    wr_valid = 1'b0; active = 1'b0;
    if (rd_valid) begin
      n = 0;
      do begin step(); n++; end while (!rd_acc && n < 50);
      chk("final_rd_grant", rd_acc, 1);
      rd_valid = 1'b0;
    end
    repeat (10) step();
    chk("end_disp_queue", dq.size(), 0);
    chk("end_rd_queue", rq.size(), 0);
    chk("end_wr_queue", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
